inst_load_sequencer: RTL and testbench
======================================

Name: inst_load_sequencer

Overview:
Boot/reload sequencer for the RISC-V pipeline core. Accepts a program as a stream of 32-bit words over a valid/ready handshake and writes each word into instruction memory through the core's enable_inst_in / INSTRUCTION / ADDRESS load interface. After a programmable settle delay it asserts start to release the pipeline. It also supports halt and reprogram while running.

Parameters:
ADDR_W, 32, width of ADDRESS.
BASE_ADDR, 0, byte address of the first loaded word; must be 4-byte aligned.
MAX_WORDS, 256, largest legal program length in words.
START_DELAY, 4, cycles between the last memory write and start rising (legal range 1..15).
CNT_W, $clog2(MAX_WORDS)+1, width of word_count.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst_n  in  1  asynchronous reset, active-low.
load_req  in  1  one-cycle request to begin a program load.
word_count  in  CNT_W  program length; sampled only when load_req is accepted.
halt  in  1  stops a running program.
in_valid  in  1  an instruction word is offered.
in_data  in  32  the offered instruction word.
in_ready  out  1  sequencer can accept a word.
enable_inst_in  out  1  instruction-memory write strobe.
INSTRUCTION  out  32  write data.
ADDRESS  out  ADDR_W  byte write address.
start  out  1  pipeline run enable (level).
busy  out  1  high in LOAD or DRAIN.
done  out  1  one-cycle pulse when a run is halted.
err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values (asynchronous, all outputs): every output is 0, state is IDLE, the word index is 0, and ADDRESS equals BASE_ADDR.
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - load_req with 1<=word_count<=MAX_WORDS: latch the count, clear the index, go to LOAD.
  - load_req with word_count of 0 or >MAX_WORDS: err=1 for one cycle; stay in IDLE.
- LOAD:
  - in_ready=1 and busy=1.
  - A transfer occurs when in_valid&&in_ready. On the next cycle: enable_inst_in=1, INSTRUCTION=in_data, ADDRESS=BASE_ADDR+4*index. Write latency is exactly 1 cycle.
  - The index increments per transfer. Back-to-back transfers are allowed at one per cycle.
  - A cycle with no transfer drives enable_inst_in=0; INSTRUCTION and ADDRESS hold their last values.
  - When the transfer of word index count-1 is accepted, the next state is DRAIN, and in_ready drops in that same next cycle.
  - load_req is ignored while in LOAD.
- DRAIN:
  - busy=1 and in_ready=0.
  - The final write strobe happens in the first DRAIN cycle.
  - The delay counter loads START_DELAY on entry and decrements each cycle; at 0, go to RUN.
- RUN:
  - start=1 and busy=0.
  - halt: start falls next cycle, done=1 for one cycle, go to IDLE.
  - load_req with a legal count and no halt: start falls next cycle, go directly to LOAD (reprogram).
  - load_req with an illegal count: err pulse; stay in RUN.
  - halt and load_req in the same cycle: halt wins and load_req is dropped.
- halt outside RUN is ignored.
- ADDRESS arithmetic is modulo 2^ADDR_W; no wrap check is made.
- Reset asserted mid-LOAD or mid-DRAIN: immediate return to IDLE with all outputs 0. Words already written stay in memory; start never rises.

Optional Feature:
INST_LOAD_CHECKSUM_EN
- Defined:
  - Adds input chk_expected[31:0], sampled with load_req, and output chk_sum[31:0].
  - chk_sum is the modulo-2^32 sum of all words accepted in the current load, cleared when a load is accepted.
  - On the DRAIN→RUN transition, if chk_sum != chk_expected: err=1 for one cycle, go to IDLE, start stays 0.
- Not defined: both ports are absent and DRAIN always proceeds to RUN.

Test Plan:
- Load 3 words 0x00500093, 0x00A00113, 0x002081B3 with in_valid held high → writes to ADDRESS 0x0, 0x4, 0x8 on consecutive cycles; start rises exactly 1+START_DELAY cycles after the last transfer (5 cycles at default).
- Same load with in_valid toggling 1,0,1,0,1 → enable_inst_in pulses only on the cycles after transfers; addresses still 0x0, 0x4, 0x8.
- load_req with word_count=0, then with 257 → err pulses once per request; state stays IDLE; in_ready stays 0.
- In RUN, pulse halt and load_req in the same cycle → start=0 next cycle, done pulse, state IDLE, no LOAD entry.
- Assert rst_n=0 after 2 of 4 words → all outputs 0 immediately; a following load of 1 word writes ADDRESS=BASE_ADDR.
- With the macro defined, load 2 words 0x1 and 0x2 with chk_expected=0x4 → err pulse, start stays 0; repeat with chk_expected=0x3 → start rises.

Source files
------------

// File: rtl/inst_load_sequencer.sv
// Purpose: boot/reload sequencer that streams program words into instruction memory, then releases the pipeline via start.
// Latency: each accepted word is written 1 cycle after transfer; start rises 1+START_DELAY cycles after the last transfer.
// Backpressure: in_ready is high only in LOAD; words are taken one per cycle whenever in_valid&&in_ready.
// Optional macro INST_LOAD_CHECKSUM_EN adds chk_expected/chk_sum and a checksum gate on entering RUN.
module inst_load_sequencer #(
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        MAX_WORDS   = 256,
  parameter int unsigned        START_DELAY = 4,
  parameter int unsigned        CNT_W       = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              halt,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              enable_inst_in,
  output logic [31:0]       INSTRUCTION,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              start,
  output logic              busy,
  output logic              done,
`ifdef INST_LOAD_CHECKSUM_EN
  input  logic [31:0]       chk_expected,
  output logic [31:0]       chk_sum,
`endif
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;       // index of the next word to be accepted
  logic [CNT_W-1:0]  cnt_q;     // program length latched at load acceptance
  logic [3:0]        dly;       // settle countdown while in DRAIN

`ifdef INST_LOAD_CHECKSUM_EN
  logic [31:0]       chk_exp_q;
`endif

  logic              count_ok;
  logic              accept;
  logic              reject;
  logic              xfer;
  logic              last_word;
  logic [ADDR_W-1:0] wr_addr;

  // Request qualification, handshake and write-address generation.
  // A load may start from IDLE, or from RUN when halt is not also asserted
  // (halt has priority and swallows a simultaneous load_req).
  always_comb begin
    count_ok  = (word_count != '0) && (word_count <= CNT_W'(MAX_WORDS));
    accept    = 1'b0;
    reject    = 1'b0;
    if (load_req) begin
      if (state == S_IDLE || (state == S_RUN && !halt)) begin
        accept = count_ok;
        reject = !count_ok;
      end
    end
    xfer      = in_valid && in_ready;
    last_word = (idx == (cnt_q - CNT_W'(1)));
    // Modulo-2^ADDR_W address; wrap past the top of the space is not checked.
    wr_addr   = BASE_ADDR + (ADDR_W'(idx) << 2);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt_q          <= '0;
      dly            <= '0;
      in_ready       <= 1'b0;
      enable_inst_in <= 1'b0;
      INSTRUCTION    <= '0;
      ADDRESS        <= BASE_ADDR;
      start          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
      chk_sum        <= '0;
      chk_exp_q      <= '0;
`endif
    end else begin
      // Pulses default low; INSTRUCTION/ADDRESS hold between writes.
      enable_inst_in <= 1'b0;
      done           <= 1'b0;
      err            <= reject;

      if (accept) begin
        // Fresh load (from IDLE or reprogram from RUN).
        state    <= S_LOAD;
        cnt_q    <= word_count;
        idx      <= '0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
        start    <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
        chk_sum   <= '0;
        chk_exp_q <= chk_expected;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            // Nothing to do until a legal request arrives.
          end

          S_LOAD: begin
            if (xfer) begin
              enable_inst_in <= 1'b1;
              INSTRUCTION    <= in_data;
              ADDRESS        <= wr_addr;
              idx            <= idx + CNT_W'(1);
`ifdef INST_LOAD_CHECKSUM_EN
              chk_sum        <= chk_sum + in_data;
`endif
              if (last_word) begin
                // Final strobe lands in the first DRAIN cycle.
                state    <= S_DRAIN;
                in_ready <= 1'b0;
                dly      <= 4'(START_DELAY);
              end
            end
          end

          S_DRAIN: begin
            if (dly == 4'd0) begin
              busy <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
              if (chk_sum != chk_exp_q) begin
                // Corrupt program: refuse to release the pipeline.
                state <= S_IDLE;
                err   <= 1'b1;
              end else begin
                state <= S_RUN;
                start <= 1'b1;
              end
`else
              state <= S_RUN;
              start <= 1'b1;
`endif
            end else begin
              dly <= dly - 4'd1;
            end
          end

          S_RUN: begin
            if (halt) begin
              state <= S_IDLE;
              start <= 1'b0;
              done  <= 1'b1;
            end
          end

          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            start    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_load_sequencer.sv
// Directed bench for inst_load_sequencer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
// Checksum scenarios are exercised only when INST_LOAD_CHECKSUM_EN is defined.
module tb_inst_load_sequencer;

  localparam int CNT_W = 9;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic [8:0]  word_count;
  logic        halt;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        enable_inst_in;
  logic [31:0] INSTRUCTION;
  logic [31:0] ADDRESS;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] chk_expected;
`ifdef INST_LOAD_CHECKSUM_EN
  logic [31:0] chk_sum;
`endif

  int checks = 0;
  int errors = 0;

  inst_load_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_req       (load_req),
    .word_count     (word_count),
    .halt           (halt),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .enable_inst_in (enable_inst_in),
    .INSTRUCTION    (INSTRUCTION),
    .ADDRESS        (ADDRESS),
    .start          (start),
    .busy           (busy),
    .done           (done),
`ifdef INST_LOAD_CHECKSUM_EN
    .chk_expected   (chk_expected),
    .chk_sum        (chk_sum),
`endif
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect start low for START_DELAY edges after the final write, then high.
  task automatic drain_to_run(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_drain_start"}, {31'b0, start}, 32'd0);
    end
    tick();
    chk({tag, "_start"}, {31'b0, start}, 32'd1);
    chk({tag, "_run_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic issue_load(input logic [8:0] n, input logic [31:0] exp_sum);
    load_req     = 1'b1;
    word_count   = n;
    chk_expected = exp_sum;
    tick();
    load_req     = 1'b0;
  endtask

  task automatic write_word(input string tag, input logic [31:0] d, input logic [31:0] a);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    chk({tag, "_en"},   {31'b0, enable_inst_in}, 32'd1);
    chk({tag, "_data"}, INSTRUCTION, d);
    chk({tag, "_addr"}, ADDRESS, a);
  endtask

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;
  localparam logic [31:0] SUM3 = 32'h0110_8359;

  initial begin
    rst_n        = 1'b0;
    load_req     = 1'b0;
    word_count   = '0;
    halt         = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    chk_expected = '0;
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_en",       {31'b0, enable_inst_in}, 32'd0);
    chk("rst_instr",    INSTRUCTION, 32'd0);
    chk("rst_addr",     ADDRESS, 32'd0);
    chk("rst_start",    {31'b0, start}, 32'd0);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    chk("rst_done",     {31'b0, done}, 32'd0);
    chk("rst_err",      {31'b0, err}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Back-to-back load of 3 words.
    issue_load(9'd3, SUM3);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t1_busy",     {31'b0, busy}, 32'd1);
    write_word("t1_w0", W0, 32'h0);
    write_word("t1_w1", W1, 32'h4);
    write_word("t1_w2", W2, 32'h8);
    in_valid = 1'b0;
    chk("t1_ready_drop", {31'b0, in_ready}, 32'd0);
    chk("t1_drain_busy", {31'b0, busy}, 32'd1);
    drain_to_run("t1");

    // Halt and load_req together: halt wins.
    halt       = 1'b1;
    load_req   = 1'b1;
    word_count = 9'd2;
    tick();
    halt     = 1'b0;
    load_req = 1'b0;
    chk("hl_start", {31'b0, start}, 32'd0);
    chk("hl_done",  {31'b0, done}, 32'd1);
    chk("hl_ready", {31'b0, in_ready}, 32'd0);
    chk("hl_busy",  {31'b0, busy}, 32'd0);
    tick();
    chk("hl_done_clr",  {31'b0, done}, 32'd0);
    chk("hl_no_load",   {31'b0, in_ready}, 32'd0);

    // Illegal counts in IDLE.
    load_req = 1'b1; word_count = 9'd0;
    tick();
    load_req = 1'b0;
    chk("bad0_err",   {31'b0, err}, 32'd1);
    chk("bad0_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bad0_err_clr", {31'b0, err}, 32'd0);
    load_req = 1'b1; word_count = 9'd257;
    tick();
    load_req = 1'b0;
    chk("bad257_err",   {31'b0, err}, 32'd1);
    chk("bad257_busy",  {31'b0, busy}, 32'd0);
    tick();
    chk("bad257_err_clr", {31'b0, err}, 32'd0);
    chk("bad257_ready",   {31'b0, in_ready}, 32'd0);

    // Gapped stream 1,0,1,0,1.
    issue_load(9'd3, SUM3);
    write_word("t2_w0", W0, 32'h0);
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    tick();
    chk("t2_gap0_en",   {31'b0, enable_inst_in}, 32'd0);
    chk("t2_gap0_hold", INSTRUCTION, W0);
    write_word("t2_w1", W1, 32'h4);
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    tick();
    chk("t2_gap1_en",   {31'b0, enable_inst_in}, 32'd0);
    chk("t2_gap1_addr", ADDRESS, 32'h4);
    write_word("t2_w2", W2, 32'h8);
    in_valid = 1'b0;
    drain_to_run("t2");

    // Illegal request while running: err, stays in RUN.
    load_req = 1'b1; word_count = 9'd300;
    tick();
    load_req = 1'b0;
    chk("runbad_err",   {31'b0, err}, 32'd1);
    chk("runbad_start", {31'b0, start}, 32'd1);

    // Reprogram from RUN with a single word.
    issue_load(9'd1, 32'h0000_ABCD);
    chk("rp_start", {31'b0, start}, 32'd0);
    chk("rp_ready", {31'b0, in_ready}, 32'd1);
    write_word("rp_w0", 32'h0000_ABCD, 32'h0);
    in_valid = 1'b0;
    drain_to_run("rp");
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("rp_done", {31'b0, done}, 32'd1);

    // Reset after 2 of 4 words.
    issue_load(9'd4, 32'h0);
    write_word("rs_w0", W0, 32'h0);
    write_word("rs_w1", W1, 32'h4);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_en",    {31'b0, enable_inst_in}, 32'd0);
    chk("rs_ready", {31'b0, in_ready}, 32'd0);
    chk("rs_busy",  {31'b0, busy}, 32'd0);
    chk("rs_addr",  ADDRESS, 32'h0);
    chk("rs_instr", INSTRUCTION, 32'h0);
    chk("rs_start", {31'b0, start}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rs_idle_start", {31'b0, start}, 32'd0);
    issue_load(9'd1, 32'h0000_0013);
    write_word("rs_after", 32'h0000_0013, 32'h0);
    in_valid = 1'b0;
    drain_to_run("rs");
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();

`ifdef INST_LOAD_CHECKSUM_EN
    // Wrong checksum blocks start.
    issue_load(9'd2, 32'h4);
    write_word("ck_w0", 32'h1, 32'h0);
    write_word("ck_w1", 32'h2, 32'h4);
    in_valid = 1'b0;
    chk("ck_sum", chk_sum, 32'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ck_drain_err", {31'b0, err}, 32'd0);
    end
    tick();
    chk("ck_bad_err",   {31'b0, err}, 32'd1);
    chk("ck_bad_start", {31'b0, start}, 32'd0);
    tick();
    chk("ck_bad_idle",  {31'b0, start}, 32'd0);
    chk("ck_err_clr",   {31'b0, err}, 32'd0);
    // Matching checksum releases start.
    issue_load(9'd2, 32'h3);
    write_word("ck2_w0", 32'h1, 32'h0);
    write_word("ck2_w1", 32'h2, 32'h4);
    in_valid = 1'b0;
    drain_to_run("ck2");
    chk("ck2_err", {31'b0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
